// File: rtl/vga_sched_pkg.sv
// Shared types and constants for the VGA stream scheduler: state encoding,
// default raster timing, RGB565->RGB888 expansion and the colour-bar table.
package vga_sched_pkg;

  typedef enum logic [2:0] {
    ST_IDLE    = 3'd0,
    ST_STARTUP = 3'd1,
    ST_ARM     = 3'd2,
    ST_STREAM  = 3'd3,
    ST_RESYNC  = 3'd4
  } sched_state_e;

  localparam int          H_ACTIVE_DEF        = 640;
  localparam int          V_ACTIVE_DEF        = 480;
  localparam int          H_START_DEF         = 1;
  localparam int          STARTUP_FRAMES_DEF  = 2;
  localparam int          UNDERFLOW_LIMIT_DEF = 16;
  localparam logic [23:0] UNDERFLOW_COLOR_DEF = 24'hFF0000;

  // Index 0 is the leftmost bar: white, yellow, cyan, green, magenta, red, blue, black.
  localparam logic [7:0][23:0] BAR_COLOR = {
    24'h000000, 24'h0000FF, 24'hFF0000, 24'hFF00FF,
    24'h00FF00, 24'h00FFFF, 24'hFFFF00, 24'hFFFFFF
  };

  function automatic logic [23:0] rgb565_to_888(input logic [15:0] d);
    return {d[15:11], 3'b000, d[10:5], 2'b00, d[4:0], 3'b000};
  endfunction

endpackage

// File: rtl/vga_stream_scheduler_if.sv
// FIFO read port plus registered pixel stream between the scheduler (master)
// and the FIFO / HDMI encoder side (slave).
interface vga_stream_scheduler_if;
  logic        fifo_empty;
  logic [15:0] fifo_data;
  logic        fifo_rd_en;
  logic [23:0] rgb888;
  logic        pixel_valid;

  modport master (input fifo_empty, fifo_data, output fifo_rd_en, rgb888, pixel_valid);
  modport slave  (output fifo_empty, fifo_data, input fifo_rd_en, rgb888, pixel_valid);
endinterface

// File: rtl/vga_sched_pixel_pipe.sv
// Registered output stage: converted FIFO word, underflow fill or colour bar,
// one cycle after the strobe that selects it.
module vga_sched_pixel_pipe
  import vga_sched_pkg::*;
#(
  parameter logic [23:0] UNDERFLOW_COLOR = UNDERFLOW_COLOR_DEF
) (
  input  logic        clock25,
  input  logic        resetn,
  input  logic        load,
  input  logic        underflow,
  input  logic        pattern,
  input  logic [2:0]  bar_idx,
  input  logic [15:0] fifo_data,
  output logic [23:0] rgb888,
  output logic        pixel_valid
);
  logic [23:0] rgb_d, rgb_q;
  logic        vld_d, vld_q;

  always_comb begin
    rgb_d = '0;
    vld_d = 1'b0;
    if (load) begin
      rgb_d = rgb565_to_888(fifo_data);
      vld_d = 1'b1;
    end else if (underflow) begin
      rgb_d = UNDERFLOW_COLOR;
      vld_d = 1'b1;
    end else if (pattern) begin
      rgb_d = BAR_COLOR[bar_idx];
      vld_d = 1'b1;
    end
  end

  always_ff @(posedge clock25 or negedge resetn) begin
    if (!resetn) begin
      rgb_q <= '0;
      vld_q <= 1'b0;
    end else begin
      rgb_q <= rgb_d;
      vld_q <= vld_d;
    end
  end

  assign rgb888      = rgb_q;
  assign pixel_valid = vld_q;
endmodule

// File: rtl/vga_stream_scheduler.sv
// Paces RGB565 FIFO reads against the VGA raster: start-up delay, frame-aligned
// start, underflow fill, camera resync. VGA_SCHED_TEST_PATTERN_EN adds a colour-bar source.
module vga_stream_scheduler
  import vga_sched_pkg::*;
#(
  parameter int          H_ACTIVE        = H_ACTIVE_DEF,
  parameter int          V_ACTIVE        = V_ACTIVE_DEF,
  parameter int          H_START         = H_START_DEF,
  parameter int          STARTUP_FRAMES  = STARTUP_FRAMES_DEF,
  parameter int          UNDERFLOW_LIMIT = UNDERFLOW_LIMIT_DEF,
  parameter logic [23:0] UNDERFLOW_COLOR = UNDERFLOW_COLOR_DEF
) (
  input  logic                   clock25,
  input  logic                   resetn,
  input  logic [9:0]             pixel_x,
  input  logic [9:0]             pixel_y,
  input  logic                   enable,
  input  logic                   cam_frame_start,
`ifdef VGA_SCHED_TEST_PATTERN_EN
  input  logic                   pattern_sel,
`endif
  vga_stream_scheduler_if.master bus,
  output logic [2:0]             sched_state,
  output logic [15:0]            underflow_cnt,
  output logic [7:0]             resync_cnt
);
  localparam logic [9:0]  X_LO     = 10'(H_START);
  localparam logic [9:0]  X_HI     = 10'(H_START + H_ACTIVE - 1);
  localparam logic [9:0]  Y_HI     = 10'(V_ACTIVE);
  localparam logic [7:0]  SU_LAST  = 8'(STARTUP_FRAMES - 1);
  localparam logic [15:0] UF_LIMIT = 16'(UNDERFLOW_LIMIT);

  sched_state_e state_q, state_d;
  logic [7:0]   frame_cnt_q, frame_cnt_d;
  logic [15:0]  frame_uf_q, frame_uf_d;
  logic [15:0]  uf_cnt_q, uf_cnt_d;
  logic [7:0]   rs_cnt_q, rs_cnt_d;
  logic         fb, vis, stream, pat_mode, pop_px, uf_px, pat_px, drain;
  logic [2:0]   bar_idx;

  assign fb  = (pixel_x == '0) && (pixel_y == '0);
  assign vis = (pixel_y < Y_HI) && (pixel_x >= X_LO) && (pixel_x <= X_HI);

`ifdef VGA_SCHED_TEST_PATTERN_EN
  assign pat_mode = pattern_sel;
  assign bar_idx  = 3'((pixel_x - X_LO) >> 6);
`else
  assign pat_mode = 1'b0;
  assign bar_idx  = 3'd0;
`endif

  // enable gates every strobe so a disable stops reads in the same cycle.
  assign stream = enable && (state_q == ST_STREAM) && vis;
  assign pop_px = stream && !pat_mode && !bus.fifo_empty;
  assign uf_px  = stream && !pat_mode && bus.fifo_empty;
  assign pat_px = stream && pat_mode;
  assign drain  = enable && (state_q == ST_RESYNC) && !bus.fifo_empty && !cam_frame_start;

  assign bus.fifo_rd_en = pop_px || drain;

  always_comb begin
    state_d     = state_q;
    frame_cnt_d = frame_cnt_q;
    frame_uf_d  = frame_uf_q;
    uf_cnt_d    = uf_cnt_q;
    rs_cnt_d    = rs_cnt_q;
    if (uf_px) begin
      if (!(&uf_cnt_q))   uf_cnt_d   = uf_cnt_q + 16'd1;
      if (!(&frame_uf_q)) frame_uf_d = frame_uf_q + 16'd1;
    end
    if (fb) frame_uf_d = '0;
    if (!enable) begin
      state_d = ST_IDLE;
    end else begin
      unique case (state_q)
        ST_IDLE:    state_d = ST_ARM;
        ST_STARTUP: if (fb) begin
                      if (frame_cnt_q == SU_LAST) state_d = ST_ARM;
                      else frame_cnt_d = frame_cnt_q + 8'd1;
                    end
        ST_ARM:     if (fb && !bus.fifo_empty) state_d = ST_STREAM;
        ST_STREAM:  if (fb && frame_uf_q >= UF_LIMIT) begin
                      state_d = ST_RESYNC;
                      if (!(&rs_cnt_q)) rs_cnt_d = rs_cnt_q + 8'd1;
                    end
        ST_RESYNC:  if (cam_frame_start) state_d = ST_ARM;
        default:    state_d = ST_STARTUP;
      endcase
    end
  end

  always_ff @(posedge clock25 or negedge resetn) begin
    if (!resetn) begin
      state_q     <= ST_STARTUP;
      frame_cnt_q <= '0;
      frame_uf_q  <= '0;
      uf_cnt_q    <= '0;
      rs_cnt_q    <= '0;
    end else begin
      state_q     <= state_d;
      frame_cnt_q <= frame_cnt_d;
      frame_uf_q  <= frame_uf_d;
      uf_cnt_q    <= uf_cnt_d;
      rs_cnt_q    <= rs_cnt_d;
    end
  end

  vga_sched_pixel_pipe #(.UNDERFLOW_COLOR(UNDERFLOW_COLOR)) u_pipe (
    .clock25     (clock25),
    .resetn      (resetn),
    .load        (pop_px),
    .underflow   (uf_px),
    .pattern     (pat_px),
    .bar_idx     (bar_idx),
    .fifo_data   (bus.fifo_data),
    .rgb888      (bus.rgb888),
    .pixel_valid (bus.pixel_valid)
  );

  assign sched_state   = state_q;
  assign underflow_cnt = uf_cnt_q;
  assign resync_cnt    = rs_cnt_q;
endmodule
